// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max pooling over a raster-ordered, CH-lane pixel stream.
// Even columns are held, odd columns complete a horizontal pair; even rows
// park their pair maxima in a half-row line buffer, odd rows combine with it.
// Build option: define MAXPOOL_CEIL_EN for ceil-mode handling of odd
// widths/heights; left undefined, odd edges are dropped (floor mode).
module maxpool2x2_stream #(
    parameter int CH      = 32,
    parameter int DW      = 8,
    parameter int MAX_COL = 256,
    parameter int AW      = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      i_fm_col,
    input  logic [15:0]      i_fm_row,
    input  logic             i_data_valid,
    input  logic [CH*DW-1:0] i_data,
    output logic [CH*DW-1:0] o_data,
    output logic             o_data_valid,
    output logic             o_pool_end,
    output logic             o_cfg_err
);

    typedef enum logic [1:0] {
        IDLE,
        ROW_EVEN,
        ROW_ODD
    } state_t;

    localparam logic [15:0] MAX_COL_W = 16'(MAX_COL);

    state_t             state_q, state_d;
    logic [15:0]        col_q, col_d;
    logic [15:0]        row_q, row_d;
    logic [15:0]        fm_col_q, fm_col_d;
    logic [15:0]        fm_row_q, fm_row_d;
    logic [CH*DW-1:0]   hold_q, hold_d;
    logic [CH*DW-1:0]   o_data_q, o_data_d;
    logic               o_valid_q, o_valid_d;
    logic               o_end_q, o_end_d;
    logic               cfg_err_q, cfg_err_d;

    logic [CH*DW-1:0]   line_buf [0:(1<<AW)-1];
    logic               lb_we;
    logic [AW-1:0]      lb_addr;
    logic [CH*DW-1:0]   lb_rdata;

    logic [15:0]        cur_col, cur_row, cur_fm_col, cur_fm_row;
    logic               cfg_legal, beat_ok, last_col, last_row, odd_row, pair_done;
    logic [CH*DW-1:0]   hmax, pooled;

    // Position of the current beat; the first beat of a frame is col 0, row 0
    // and uses the geometry presented on the inputs in that same cycle.
    always_comb begin
        cur_col    = (state_q == IDLE) ? 16'd0 : col_q;
        cur_row    = (state_q == IDLE) ? 16'd0 : row_q;
        cur_fm_col = (state_q == IDLE) ? i_fm_col : fm_col_q;
        cur_fm_row = (state_q == IDLE) ? i_fm_row : fm_row_q;
        cfg_legal  = (i_fm_col >= 16'd2) && (i_fm_col <= MAX_COL_W) && (i_fm_row >= 16'd2);
        beat_ok    = i_data_valid && ((state_q != IDLE) || cfg_legal);
        last_col   = (cur_col == cur_fm_col - 16'd1);
        last_row   = (cur_row == cur_fm_row - 16'd1);
        odd_row    = (state_q == ROW_ODD);
        lb_addr    = cur_col[AW:1];
        lb_rdata   = line_buf[lb_addr];
`ifdef MAXPOOL_CEIL_EN
        pair_done  = cur_col[0] || last_col;
`else
        pair_done  = cur_col[0];
`endif
    end

    // Lane-wise unsigned maxima: horizontal pair, then against the line buffer.
    always_comb begin
        hmax   = '0;
        pooled = '0;
        for (int k = 0; k < CH; k++) begin
            hmax[DW*k +: DW] = (hold_q[DW*k +: DW] > i_data[DW*k +: DW]) ?
                               hold_q[DW*k +: DW] : i_data[DW*k +: DW];
        end
`ifdef MAXPOOL_CEIL_EN
        // A lone last column of an odd-width row stands as its own pair.
        if (!cur_col[0]) begin
            hmax = i_data;
        end
`endif
        for (int k = 0; k < CH; k++) begin
            pooled[DW*k +: DW] = (lb_rdata[DW*k +: DW] > hmax[DW*k +: DW]) ?
                                 lb_rdata[DW*k +: DW] : hmax[DW*k +: DW];
        end
    end

    // Next-state, counters, line-buffer write strobe and output staging.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        fm_col_d  = fm_col_q;
        fm_row_d  = fm_row_q;
        hold_d    = hold_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;
        o_end_d   = 1'b0;
        cfg_err_d = cfg_err_q;
        lb_we     = 1'b0;

        if ((state_q == IDLE) && i_data_valid && !cfg_legal) begin
            cfg_err_d = 1'b1;
        end

        if (beat_ok) begin
            if (state_q == IDLE) begin
                fm_col_d = i_fm_col;
                fm_row_d = i_fm_row;
            end
            if (!cur_col[0]) begin
                hold_d = i_data;
            end
            if (pair_done) begin
                if (odd_row) begin
                    o_data_d  = pooled;
                    o_valid_d = 1'b1;
                end
`ifdef MAXPOOL_CEIL_EN
                else if (last_row) begin
                    o_data_d  = hmax;
                    o_valid_d = 1'b1;
                end
`endif
                else begin
                    lb_we = 1'b1;
                end
            end
            if (last_col && last_row) begin
                col_d   = 16'd0;
                row_d   = 16'd0;
                state_d = IDLE;
                o_end_d = 1'b1;
            end else if (last_col) begin
                col_d   = 16'd0;
                row_d   = cur_row + 16'd1;
                state_d = odd_row ? ROW_EVEN : ROW_ODD;
            end else begin
                col_d   = cur_col + 16'd1;
                row_d   = cur_row;
                state_d = odd_row ? ROW_ODD : ROW_EVEN;
            end
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            fm_col_q  <= '0;
            fm_row_q  <= '0;
            hold_q    <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_end_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            fm_col_q  <= fm_col_d;
            fm_row_q  <= fm_row_d;
            hold_q    <= hold_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_end_q   <= o_end_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Half-row line buffer; contents are meaningless until written by an even row.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[lb_addr] <= hmax;
        end
    end

    assign o_data       = o_data_q;
    assign o_data_valid = o_valid_q;
    assign o_pool_end   = o_end_q;
    assign o_cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream with a window-based reference model and
// a timed scoreboard. Honours MAXPOOL_CEIL_EN the same way as the design.
module tb_maxpool2x2_stream;

    localparam int CH = 32;
    localparam int DW = 8;
    localparam int W  = CH * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   i_fm_col, i_fm_row;
    logic          i_data_valid;
    logic [W-1:0]  i_data;
    logic [W-1:0]  o_data;
    logic          o_data_valid, o_pool_end, o_cfg_err;

    maxpool2x2_stream dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_fm_col     (i_fm_col),
        .i_fm_row     (i_fm_row),
        .i_data_valid (i_data_valid),
        .i_data       (i_data),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_pool_end   (o_pool_end),
        .o_cfg_err    (o_cfg_err)
    );

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t          exp_q[$];
    int            end_q[$];
    logic [W-1:0]  obs_q[$];
    int            end_obs_q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    bit            exp_end;
    exp_t          e;

    // Free-running clock and a cycle counter used to time expected outputs.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: samples on the falling edge, pops expectations as the DUT emits.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (o_data_valid === 1'b1) begin
                obs_q.push_back(o_data);
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("[TB] FAIL unexpected_output cyc=%0d observed=%h required=none", cyc, o_data);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (o_data === e.data) else begin
                        failures++;
                        $error("[TB] FAIL out_data observed=%h required=%h", o_data, e.data);
                    end
                    checks++;
                    assert (cyc === e.due) else begin
                        failures++;
                        $error("[TB] FAIL out_latency observed_cyc=%0d required_cyc=%0d", cyc, e.due);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                checks++;
                assert (o_data_valid === 1'b1) else begin
                    failures++;
                    $error("[TB] FAIL missing_output observed_valid=%b required_valid=1 due=%0d", o_data_valid, exp_q[0].due);
                end
                void'(exp_q.pop_front());
            end
            exp_end = (end_q.size() > 0) && (end_q[0] == cyc);
            checks++;
            assert (o_pool_end === exp_end) else begin
                failures++;
                $error("[TB] FAIL pool_end cyc=%0d observed=%b required=%b", cyc, o_pool_end, exp_end);
            end
            if (end_q.size() > 0 && end_q[0] <= cyc) void'(end_q.pop_front());
            if (o_pool_end === 1'b1) end_obs_q.push_back(cyc);
        end
    end

    function automatic logic [W-1:0] lane_max(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int k = 0; k < CH; k++) begin
            r[DW*k +: DW] = (a[DW*k +: DW] > b[DW*k +: DW]) ? a[DW*k +: DW] : b[DW*k +: DW];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h required=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] px, input int cols, input int rows,
                                 input bit has_out, input logic [W-1:0] exp_val, input bit is_last);
        exp_t t;
        @(negedge clk);
        i_data_valid = 1'b1;
        i_data       = px;
        i_fm_col     = 16'(cols);
        i_fm_row     = 16'(rows);
        if (has_out) begin
            t.data = exp_val;
            t.due  = cyc + 1;
            exp_q.push_back(t);
        end
        if (is_last) end_q.push_back(cyc + 1);
    endtask

    task automatic idleCycle();
        @(negedge clk);
        i_data_valid = 1'b0;
        i_data       = {8{$urandom()}};
    endtask

    // Builds a frame, derives expected pooled pixels from whole 2x2 windows,
    // and drives the first nbeats beats with 'gap' idle cycles after each.
    task automatic run_frame(input int cols, input int rows, input int mode, input int gap, input int nbeats);
        logic [W-1:0] px  [0:63];
        logic [W-1:0] val [0:63];
        bit           has [0:63];
        int oc, orw, rhi, chi;
        logic [W-1:0] v;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                logic [W-1:0] p;
                p = '0;
                for (int k = 0; k < CH; k++) begin
                    if (mode == 0)      p[DW*k +: DW] = (k == 0) ? 8'(r*cols + c) : 8'd0;
                    else if (mode == 1) p[DW*k +: DW] = (k == CH-1) ? 8'd0 : 8'd127;
                    else                p[DW*k +: DW] = 8'($urandom_range(0, 127));
                end
                px[r*cols + c]  = p;
                has[r*cols + c] = 1'b0;
                val[r*cols + c] = '0;
            end
        end
`ifdef MAXPOOL_CEIL_EN
        oc  = (cols + 1) / 2;
        orw = (rows + 1) / 2;
`else
        oc  = cols / 2;
        orw = rows / 2;
`endif
        for (int r2 = 0; r2 < orw; r2++) begin
            for (int c2 = 0; c2 < oc; c2++) begin
                rhi = (2*r2 + 1 < rows) ? 2*r2 + 1 : rows - 1;
                chi = (2*c2 + 1 < cols) ? 2*c2 + 1 : cols - 1;
                v = '0;
                for (int rr = 2*r2; rr <= rhi; rr++)
                    for (int cc = 2*c2; cc <= chi; cc++)
                        v = lane_max(v, px[rr*cols + cc]);
                has[rhi*cols + chi] = 1'b1;
                val[rhi*cols + chi] = v;
            end
        end
        for (int i = 0; i < nbeats; i++) begin
            applyStimulus(px[i], cols, rows, has[i], val[i], i == cols*rows - 1);
            repeat (gap) idleCycle();
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() > 0 || end_q.size() > 0) && n < 30) begin
            idleCycle();
            n++;
        end
        checks++;
        assert (exp_q.size() == 0 && end_q.size() == 0) else begin
            failures++;
            $error("[TB] FAIL %s_drain observed_pending=%0d required_pending=0", tag, exp_q.size() + end_q.size());
        end
        repeat (2) idleCycle();
    endtask

    task automatic check_lane0(input string tag, input int expv[$]);
        checkOutput({tag, "_count"}, W'(obs_q.size()), W'(expv.size()));
        for (int i = 0; i < expv.size(); i++) begin
            checkOutput({tag, "_lane0"}, W'(obs_q[i][7:0]), W'(expv[i]));
        end
    endtask

    initial begin
        int exp44[$];
        int exp53[$];
        logic [W-1:0] sat_vec;
        exp44 = {5, 7, 13, 15};
`ifdef MAXPOOL_CEIL_EN
        exp53 = {6, 8, 9, 11, 13, 14};
`else
        exp53 = {6, 8};
`endif
        sat_vec = '0;
        for (int k = 0; k < CH-1; k++) sat_vec[DW*k +: DW] = 8'd127;

        rst_n = 1'b0; i_data_valid = 1'b0; i_data = '0; i_fm_col = 16'd4; i_fm_row = 16'd4;
        #1;
        checkOutput("rst_data", o_data, '0);
        checkOutput("rst_valid", W'(o_data_valid), '0);
        checkOutput("rst_end", W'(o_pool_end), '0);
        checkOutput("rst_cfg_err", W'(o_cfg_err), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        $display("[TB] 4x4 contiguous frame");
        obs_q.delete();
        run_frame(4, 4, 0, 0, 16);
        drain("f4x4");
        check_lane0("f4x4", exp44);

        $display("[TB] 4x2 gapped frame, saturated lanes");
        obs_q.delete();
        run_frame(4, 2, 1, 1, 8);
        drain("f4x2");
        checkOutput("f4x2_count", W'(obs_q.size()), W'(2));
        checkOutput("f4x2_px0", obs_q[0], sat_vec);
        checkOutput("f4x2_px1", obs_q[1], sat_vec);

        $display("[TB] 5x3 odd geometry frame");
        obs_q.delete();
        run_frame(5, 3, 0, 0, 15);
        drain("f5x3");
        check_lane0("f5x3", exp53);

        $display("[TB] illegal column count");
        obs_q.delete();
        end_obs_q.delete();
        for (int i = 0; i < 4; i++) applyStimulus({8{$urandom()}}, 1, 4, 1'b0, '0, 1'b0);
        idleCycle();
        checkOutput("cfg_err_set", W'(o_cfg_err), W'(1));
        repeat (10) idleCycle();
        checkOutput("cfg_err_sticky", W'(o_cfg_err), W'(1));
        checkOutput("cfg_no_output", W'(obs_q.size()), W'(0));
        checkOutput("cfg_no_end", W'(end_obs_q.size()), W'(0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("cfg_err_cleared", W'(o_cfg_err), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset mid-frame, then fresh frame");
        obs_q.delete();
        run_frame(4, 4, 2, 0, 6);
        idleCycle();
        #1;
        checkOutput("pre_rst_valid", W'(o_data_valid), W'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", W'(o_data_valid), W'(0));
        checkOutput("async_rst_data", o_data, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        run_frame(4, 4, 2, 0, 16);
        drain("fresh4x4");
        checkOutput("fresh4x4_count", W'(obs_q.size()), W'(4));

        $display("[TB] back-to-back 2x2 frames");
        obs_q.delete();
        end_obs_q.delete();
        run_frame(2, 2, 2, 0, 4);
        run_frame(2, 2, 2, 0, 4);
        drain("b2b");
        checkOutput("b2b_count", W'(obs_q.size()), W'(2));
        checkOutput("b2b_end_count", W'(end_obs_q.size()), W'(2));
        checkOutput("b2b_end_spacing", W'(end_obs_q[1] - end_obs_q[0]), W'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
